// File: rtl/keypad_scanner_pkg.sv
// Shared game definitions: note codes, keypad FSM states and the
// single-key frame encoder used by the matrix scanner.
package keypad_scanner_pkg;

  localparam logic [3:0] NOTE_NONE = 4'd0;
  localparam logic [3:0] NOTE_MIN  = 4'd1;
  localparam logic [3:0] NOTE_MAX  = 4'd8;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } keypad_state_e;

  // Exactly one bit set -> bit index + 1; none or several -> NOTE_NONE.
  function automatic logic [3:0] frame_code(input logic [7:0] snap);
    logic [3:0] code;
    logic [3:0] ones;
    code = NOTE_NONE;
    ones = '0;
    for (int i = 0; i < 8; i++) begin
      if (snap[i]) begin
        ones = ones + 4'd1;
        code = 4'(i + 1);
      end
    end
    return (ones == 4'd1) ? code : NOTE_NONE;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Width-parameterised two-flop synchroniser for asynchronous inputs.
module sync_2ff #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 2x4 keypad matrix scanner: row scan, frame debounce and press FSM that
// feeds note codes 1..8 to the game core.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  input  logic       lock,
  output logic [1:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_CNT);

  logic [3:0]    col_sync;
  logic [3:0]    cols_pressed;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          row_q, row_d;
  logic [7:0]    snap_q, snap_d;
  logic [3:0]    cand_q, cand_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [3:0]    accepted_q, accepted_d;
  keypad_state_e state_q, state_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          terminal;
  logic          frame_end;
  logic [3:0]    fcode;

  // Columns idle high, so the synchroniser resets to "nothing pressed".
  sync_2ff #(
    .WIDTH     (4),
    .RESET_VAL (4'hF)
  ) u_col_sync (
    .clk (clk),
    .rst (reset),
    .d_i (col_in),
    .q_o (col_sync)
  );

  assign cols_pressed = ~col_sync;
  assign terminal     = (dwell_q == DWELL_LAST);
  assign frame_end    = terminal & row_q;

  always_comb begin
    dwell_d = dwell_q + DW'(1);
    row_d   = row_q;
    snap_d  = snap_q;
    if (terminal) begin
      dwell_d = '0;
      row_d   = ~row_q;
      if (row_q) snap_d[7:4] = cols_pressed;
      else       snap_d[3:0] = cols_pressed;
    end
  end

  // Encode the snapshot including the row1 columns latched this same edge.
  assign fcode = frame_code(snap_d);

  always_comb begin
    cand_d     = cand_q;
    stable_d   = stable_q;
    accepted_d = accepted_q;
    if (frame_end) begin
      if (fcode == cand_q) begin
        if (stable_q != STABLE_MAX) begin
          stable_d = stable_q + SW'(1);
          if (stable_q + SW'(1) == STABLE_MAX) accepted_d = cand_q;
        end
      end else begin
        cand_d   = fcode;
        stable_d = SW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accepted_q != NOTE_NONE) begin
          state_d = PRESSED;
          if (!lock) begin
            code_d  = accepted_q;
            valid_d = 1'b1;
          end
        end
      end
      PRESSED: begin
        if (accepted_q == NOTE_NONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_q    <= '0;
      row_q      <= 1'b0;
      snap_q     <= '0;
      cand_q     <= NOTE_NONE;
      stable_q   <= '0;
      accepted_q <= NOTE_NONE;
      state_q    <= IDLE;
      code_q     <= NOTE_NONE;
      valid_q    <= 1'b0;
    end else begin
      dwell_q    <= dwell_d;
      row_q      <= row_d;
      snap_q     <= snap_d;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      accepted_q <= accepted_d;
      state_q    <= state_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
    end
  end

  assign row_n     = row_q ? 2'b01 : 2'b10;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = (state_q == PRESSED);

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 2-row x 4-column button matrix. Synchronises and debounces the column returns and encodes the single pressed key as a note code 1..8. Emits a one-cycle press strobe plus a stable code. Sits directly upstream of the game core and drives its keypad_input / keypad_enable pair; the game's music-playing status feeds back as a lock.

Parameters:
SCAN_DIV, 50000, clk cycles each row is driven before its columns are sampled (>=2)
DEBOUNCE_CNT, 4, consecutive identical full-matrix frames required to accept a change (>=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
col_in  input  4  raw matrix column returns, active-low, asynchronous to clk
lock  input  1  high = presses are consumed without strobe (game busy playing)
row_n  output  2  matrix row drive, active-low, exactly one bit low at a time
key_code  output  4  last accepted note code 1..8; 0 before first press
key_valid  output  1  one-cycle strobe when a new press is accepted while unlocked
key_held  output  1  high while an accepted key remains pressed

Behaviour:
- Reset values: row_n=2'b10 (row0 driven), key_code=0, key_valid=0, key_held=0; all counters, snapshot, candidate and state cleared. Reset mid-scan or mid-press returns to this state; no strobe is produced on reset release.
- Synchroniser: 2-flop on col_in, then inverted so 1 means pressed. All decisions use synced values only.
- Row timing: dwell counter counts 0..SCAN_DIV-1, width $clog2(SCAN_DIV).
  - At terminal count: latch synced cols into the snapshot for the current row, toggle row_n, reset the counter.
  - Frame end is the terminal count while row1 is driven.
- Frame code, from the 8-bit snapshot, bit index = row*4+col:
  - 0 if no bits are set.
  - index+1 (1..8) if exactly one bit is set.
  - 0 if two or more bits are set (multi-press is treated as released).
- Debounce, evaluated only at frame end:
  - If frame code == candidate: stable_cnt increments, saturating at DEBOUNCE_CNT.
  - Else: candidate <= frame code and stable_cnt <= 1.
  - accepted <= candidate on the frame end where stable_cnt becomes DEBOUNCE_CNT.
- FSM with states IDLE and PRESSED, evaluated the cycle after accepted updates:
  - IDLE -> PRESSED when accepted != 0. Sets key_held=1. key_code <= accepted only if lock=0, and in that case key_valid=1 for exactly one cycle. If lock=1, the press is consumed: no strobe, key_code unchanged.
  - PRESSED -> IDLE when accepted == 0: key_held=0, key_code retained.
  - A change from one nonzero key to another nonzero key while in PRESSED is ignored. A new strobe requires passing through release.
  - Deasserting lock while a key is held produces no strobe.
- Latency: a clean press produces key_valid 1 cycle after the DEBOUNCE_CNT-th consecutive matching frame end, excluding the 2-cycle synchroniser. Release is detected with the same frame count.
- Bounce: any frame code differing from the candidate restarts the count; glitches shorter than one row dwell may be missed entirely, which is acceptable.
- key_valid is never asserted on two consecutive cycles.

Decomposition:
- Shared game package holds:
  - NOTE_NONE=4'd0, NOTE_MIN=4'd1, NOTE_MAX=4'd8
  - the keypad FSM state typedef (IDLE, PRESSED)
  - the frame-code encoding function
- One natural sub-module, sync_2ff (width-parameterised 2-flop synchroniser), which the codebase reuses elsewhere.
- Scan, debounce and FSM stay in keypad_scanner.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3):
1. Reset check: reset held, then released with col_in=4'hF. Required: row_n toggles 10->01 every 4 cycles; key_valid is never asserted; key_code=0 and key_held=0 throughout.
2. Clean press: row1/col2 pressed steadily (col_in bit2 low while row_n=01). Required: key_valid exactly once, key_code=7, key_held=1. Released for 3+ frames: key_held=0, key_code stays 7.
3. Bouncy press: row0/col0 toggled each frame for 4 frames, then held. Required: no strobe during bounce; one strobe with key_code=1 after 3 stable frames.
4. Multi-press: key 1 and key 6 held together. Required: no strobe and key_held=0. Key 6 alone thereafter: strobe with key_code=6.
5. Lock: lock=1, key 3 pressed and accepted. Required: key_held=1, no strobe, key_code unchanged. Deassert lock while still held: no strobe. Release, then press again: strobe with key_code=3.
6. Reset mid-press: key 5 held in PRESSED, reset asserted for 1 cycle. Required: all outputs at reset values immediately. Key still held after reset: a fresh strobe with key_code=5 after 3 frames.
